mips_cpu_muldiv_ctrl: RTL
=========================

Name: mips_cpu_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer. It owns the architectural HI/LO registers for the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode, runs the operation over several cycles, and writes HI/LO on completion. It stalls MFHI/MFLO reads while an operation is in flight, which lets the main ALU stay single-cycle.

Parameters:
MUL_LAT, 4, multiply latency in cycles from acceptance edge to HI/LO write edge (legal range 1..8)
DIV_ITER, 32, restoring-division iterations (fixed at 32 for 32-bit operands)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  decode presents an operation
op_code  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (accepted, no effect)
op_a  in  32  rs value (dividend / multiplicand / MTHI/MTLO source)
op_b  in  32  rt value (divisor / multiplier)
op_ready  out  1  unit can accept an op this cycle
abort  in  1  cancel in-flight op (exception/flush)
mf_req  in  1  MFHI/MFLO in decode
mf_sel  in  1  0=LO 1=HI
mf_data  out  32  selected HI/LO value, combinational
stall  out  1  pipeline must hold (mf_req or op_valid while busy)
done  out  1  one-cycle pulse after HI/LO written by MULT/DIV
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, hi=lo=0, done=0, counter=0, internal operands cleared. op_ready=1 once rst is high.
- States: IDLE, MUL, DIV, FIX.
- op_ready = (state==IDLE) && !abort. An op is accepted on a rising edge where op_valid && op_ready.
- MTHI/MTLO: hi (or lo) <= op_a on the acceptance edge; the other register is unchanged. No busy period, no done pulse.
- MULT/MULTU: latch operands, IDLE->MUL, counter=MUL_LAT-1.
  - In MUL the counter decrements each cycle.
  - On the edge where counter==0: {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU), ->IDLE.
  - Write occurs MUL_LAT edges after acceptance.
- DIV/DIVU: IDLE->DIV. Operands are latched as magnitudes (|a|,|b| for DIV; raw for DIVU) together with the sign flags.
  - DIV_ITER cycles of restoring shift-subtract, one quotient bit per cycle.
  - Then DIV->FIX for one cycle. In FIX: quotient negated if signs differ (DIV only); remainder takes the sign of the dividend.
  - On FIX exit: lo <= quotient, hi <= remainder, ->IDLE. Write occurs DIV_ITER+1 = 33 edges after acceptance.
- Divide by zero (op_b==0): same 33-cycle timing; lo <= 32'hFFFFFFFF, hi <= op_a unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo <= 0x80000000, hi <= 0. No trap.
- done: high for exactly the one cycle following a MUL/DIV write edge. In that cycle op_ready=1, so back-to-back ops are allowed.
- mf_data = mf_sel ? hi : lo. Reads the registered value, so the done cycle sees the new result.
- stall = (state!=IDLE) && (mf_req || op_valid). A read coinciding with acceptance of MTHI/MTLO in the same cycle sees the old value; decode orders these.
- abort while busy: ->IDLE on next edge, hi/lo unchanged, no done. abort in IDLE blocks acceptance that cycle.
- abort on the same edge as the final write: abort wins, no write.
- Reserved op_code: accepted, no state change, no done.
- rst asserted mid-operation: immediate return to the reset state; the partial result is discarded.

Test Plan:
- Reset, MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi/lo updated on each acceptance edge; done stays 0; mf_sel=1 reads 0x12345678.
- MULT 0xFFFFFFFE x 0x00000003 (MUL_LAT=4) -> op_ready low 4 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7 / 2 -> 33 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
- MFLO issued 2 cycles into a MULT -> stall high until the write edge; mf_data in the done cycle equals the new lo; a second MULT issued in the done cycle is accepted.
- Abort at DIV iteration 10 with hi=lo=0xA5A5A5A5 -> IDLE next cycle, hi/lo unchanged, no done. Async rst pulse mid-MULT -> hi=lo=0 immediately.

Source files
------------

// File: rtl/mips_cpu_muldiv_ctrl.sv
// mips_cpu_muldiv_ctrl: multi-cycle multiply/divide sequencer owning the
// architectural HI/LO registers. Multiplies complete after MUL_LAT cycles,
// divides use a 32-step restoring algorithm followed by a sign-fixup cycle.
module mips_cpu_muldiv_ctrl #(
  parameter int MUL_LAT  = 4,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        abort,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_ITER - 1);

  state_t      state;
  state_t      next_state;
  logic [4:0]  counter;

  // opa holds the multiplicand, or the dividend magnitude that shifts into
  // the quotient during division; opb holds the multiplier or divisor magnitude.
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] rem;
  logic        is_signed;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic        accept;
  logic        mul_write;
  logic        fix_write;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept    = op_valid && op_ready;
  assign mul_write = (state == MUL) && (counter == 5'd0) && !abort;
  assign fix_write = (state == FIX) && !abort;

  // Divide operands are converted to magnitudes at acceptance; the sign
  // flags restore the MIPS result signs in the FIX cycle.
  assign div_signed = (op_code == OP_DIV);
  assign a_mag = (div_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
  assign b_mag = (div_signed && op_b[31]) ? (32'd0 - op_b) : op_b;

  // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve
  // both MULT and MULTU, since the low 64 bits of the product are identical.
  assign a_ext   = is_signed ? {{32{opa[31]}}, opa} : {32'd0, opa};
  assign b_ext   = is_signed ? {{32{opb[31]}}, opb} : {32'd0, opb};
  assign product = a_ext * b_ext;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  assign shifted = {rem, opa[31]};
  assign diff    = shifted - {1'b0, opb};
  assign ge      = (shifted >= {1'b0, opb});

  // A zero divisor leaves every trial subtraction succeeding, so the
  // remainder path naturally ends up holding the dividend; only LO is forced.
  assign q_fix = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - opa) : opa);
  assign r_fix = neg_r ? (32'd0 - rem) : rem;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; abort always returns to IDLE without a write
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_code == OP_MULT || op_code == OP_MULTU)   next_state = MUL;
          else if (op_code == OP_DIV || op_code == OP_DIVU) next_state = DIV;
        end
      end
      MUL:  if (abort || counter == 5'd0) next_state = IDLE;
      DIV: begin
        if (abort)                 next_state = IDLE;
        else if (counter == 5'd0)  next_state = FIX;
      end
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: handshake, pipeline stall and combinational HI/LO read port
  always_comb begin
    op_ready = (state == IDLE) && !abort;
    stall    = (state != IDLE) && (mf_req || op_valid);
    mf_data  = mf_sel ? hi : lo;
  end

  // Datapath: operand capture, iteration, HI/LO writes and the done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      done      <= 1'b0;
      counter   <= 5'd0;
      opa       <= 32'd0;
      opb       <= 32'd0;
      rem       <= 32'd0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= mul_write || fix_write;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_code)
              OP_MULT, OP_MULTU: begin
                opa       <= op_a;
                opb       <= op_b;
                is_signed <= (op_code == OP_MULT);
                counter   <= MUL_LOAD;
              end
              OP_DIV, OP_DIVU: begin
                opa      <= a_mag;
                opb      <= b_mag;
                rem      <= 32'd0;
                neg_q    <= div_signed && (op_a[31] ^ op_b[31]);
                neg_r    <= div_signed && op_a[31];
                div_zero <= (op_b == 32'd0);
                counter  <= DIV_LOAD;
              end
              OP_MTHI: hi <= op_a;
              OP_MTLO: lo <= op_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (!abort) begin
            if (counter == 5'd0) {hi, lo} <= product;
            else                 counter  <= counter - 5'd1;
          end
        end
        DIV: begin
          if (!abort) begin
            rem <= ge ? diff[31:0] : shifted[31:0];
            opa <= {opa[30:0], ge};
            if (counter != 5'd0) counter <= counter - 5'd1;
          end
        end
        FIX: begin
          if (!abort) begin
            lo <= q_fix;
            hi <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
